// File: rtl/dcm_lock_ctrl.sv
// dcm_lock_ctrl: sequences DCM_SP reset, lock qualification, settle delay, retries and fault for the system reset
module dcm_lock_ctrl #(
  parameter int RST_HOLD     = 8,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SETTLE       = 1024,
  parameter int MAX_RETRY    = 7
) (
  input  logic       CLK_IN1,
  input  logic       RST,
  input  logic       DCM_LOCKED,
  input  logic [7:0] DCM_STATUS,
  output logic       DCM_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] RETRY_CNT
);
  typedef enum logic [2:0] {S_RESET_DCM, S_WAIT_LOCK, S_SETTLE, S_RUN, S_FAULT} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [2:0] retry_n;
  logic lock_m, lock_s, clk_stop, fail;
  logic status_unused;
  assign clk_stop = DCM_STATUS[1];
  assign status_unused = ^{DCM_STATUS[7:2], DCM_STATUS[0]};
  assign cnt_inc = (cnt == 16'hffff) ? cnt : cnt + 16'd1;
  // next state, shared state timer and retry count; a lost lock or stopped CLKIN beats a completed settle
  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    retry_n = RETRY_CNT;
    fail    = 1'b0;
    case (state)
      S_RESET_DCM: if (cnt == 16'(RST_HOLD - 1)) begin
        state_n = S_WAIT_LOCK;
        cnt_n   = '0;
      end
      S_WAIT_LOCK: if (lock_s) begin
        state_n = S_SETTLE;
        cnt_n   = '0;
      end else fail = (cnt == 16'(LOCK_TIMEOUT - 1));
      S_SETTLE: if (!lock_s || clk_stop) fail = 1'b1;
      else if (cnt == 16'(SETTLE - 1)) begin
        state_n = S_RUN;
        cnt_n   = '0;
        retry_n = '0;
      end
      S_RUN: begin
        cnt_n   = '0;
        state_n = (!lock_s || clk_stop) ? S_RESET_DCM : S_RUN;
      end
      S_FAULT: cnt_n = '0;
      default: begin
        state_n = S_RESET_DCM;
        cnt_n   = '0;
      end
    endcase
    if (fail) begin
      cnt_n   = '0;
      state_n = (RETRY_CNT == 3'(MAX_RETRY)) ? S_FAULT : S_RESET_DCM;
      retry_n = (RETRY_CNT == 3'(MAX_RETRY)) ? RETRY_CNT : RETRY_CNT + 3'd1;
    end
  end
  // state, synchronizer and outputs registered from the next state so they change with the state
  always_ff @(posedge CLK_IN1) begin
    if (RST) begin
      state     <= S_RESET_DCM;
      cnt       <= '0;
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      RETRY_CNT <= '0;
      DCM_RST   <= 1'b1;
      SYS_RST   <= 1'b1;
      READY     <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lock_m    <= DCM_LOCKED;
      lock_s    <= lock_m;
      RETRY_CNT <= retry_n;
      DCM_RST   <= (state_n == S_RESET_DCM) || (state_n == S_FAULT);
      SYS_RST   <= state_n != S_RUN;
      READY     <= state_n == S_RUN;
      FAULT     <= state_n == S_FAULT;
    end
  end
endmodule

// File: doc/dcm_lock_ctrl.md
DCM_LOCK_CTRL -- requirements
Module: dcm_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD, default 8, cycles DCM_RST is held high per reset pulse (min 3).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, cycles allowed for lock after DCM_RST release (16-bit counter).
REQ-003 SHALL have parameter SETTLE, default 1024, cycles lock must stay stable before SYS_RST release.
REQ-004 SHALL have parameter MAX_RETRY, default 7, DCM reset retries before fault (range 0-7).
REQ-005 SHALL have port CLK_IN1  in  1  free-running reference clock; the only clock.
REQ-006 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-007 SHALL have port DCM_LOCKED  in  1  DCM_SP LOCKED, asynchronous to CLK_IN1.
REQ-008 SHALL have port DCM_STATUS  in  8  DCM_SP STATUS; only bit 1 (CLKIN stopped) is used.
REQ-009 SHALL have port DCM_RST  out  1  DCM_SP RST drive.
REQ-010 SHALL have port SYS_RST  out  1  active-high reset for logic clocked by the DCM output.
REQ-011 SHALL have port READY  out  1  high only in RUN.
REQ-012 SHALL have port FAULT  out  1  retries exhausted; sticky until RST.
REQ-013 SHALL have port RETRY_CNT  out  3  retries since the last entry to RUN.

Function
REQ-014 SHALL pass DCM_LOCKED through a 2-flop synchronizer (lock_s); DCM_STATUS[1] SHALL be used unsynchronized.
REQ-015 SHALL implement FSM states RESET_DCM, WAIT_LOCK, SETTLE, RUN, FAULT; all outputs registered.
REQ-016 RESET_DCM: DCM_RST=1, SYS_RST=1; after exactly RST_HOLD cycles -> WAIT_LOCK with timer cleared.
REQ-017 WAIT_LOCK: DCM_RST=0; lock_s=1 -> SETTLE; else timer reaching LOCK_TIMEOUT -> retry path.
REQ-018 SETTLE: lock_s=0 or STATUS[1]=1 -> retry path; else after SETTLE consecutive cycles -> RUN.
REQ-019 Retry path: if RETRY_CNT==MAX_RETRY -> FAULT; else RETRY_CNT+1 and -> RESET_DCM.
REQ-020 RUN: SYS_RST=0, READY=1, RETRY_CNT cleared on entry; lock_s=0 or STATUS[1]=1 -> RESET_DCM, no RETRY_CNT increment.
REQ-021 FAULT: DCM_RST=1, SYS_RST=1, READY=0, FAULT=1; exit only via RST.
REQ-022 Latency: DCM_LOCKED rising, sampled at edge n and held, SHALL give SYS_RST=0 and READY=1 at edge n+2+SETTLE.
REQ-023 RUN exit SHALL drive SYS_RST=1 and READY=0 on the edge after the loss condition is seen.
REQ-024 Simultaneous lock_s=1 and timeout in WAIT_LOCK: lock wins (-> SETTLE).
REQ-025 Simultaneous lock_s=1 and STATUS[1]=1 in SETTLE: STATUS wins (retry path).
REQ-026 Counters SHALL saturate, never wrap; the SETTLE counter SHALL clear on every SETTLE entry.

Reset
REQ-027 RST=1 at any edge, any state, SHALL give next cycle: state RESET_DCM, DCM_RST=1, SYS_RST=1, READY=0, FAULT=0, RETRY_CNT=0, all counters 0, synchronizer flops 0.
REQ-028 After RST falls, the first DCM_RST pulse SHALL last exactly RST_HOLD cycles.

Verification (RST_HOLD=4, LOCK_TIMEOUT=20, SETTLE=8, MAX_RETRY=2)
REQ-029 Bench SHALL cover: release RST, DCM_LOCKED=1 five cycles after DCM_RST falls -> DCM_RST high 4 cycles; SYS_RST=0, READY=1 exactly 10 cycles after DCM_LOCKED rises.
REQ-030 Bench SHALL cover: DCM_LOCKED held 0 -> three 4-cycle DCM_RST pulses each followed by 20-cycle wait; then FAULT=1, RETRY_CNT=2, DCM_RST=1 held.
REQ-031 Bench SHALL cover: DCM_LOCKED drops for 3 cycles mid-SETTLE -> RESET_DCM, RETRY_CNT=1, SETTLE count restarts on relock.
REQ-032 Bench SHALL cover: in RUN, DCM_STATUS[1]=1 for 1 cycle -> SYS_RST=1, READY=0 next edge; DCM_RST 4-cycle pulse; RETRY_CNT=0.
REQ-033 Bench SHALL cover: RST pulsed 1 cycle during WAIT_LOCK and during FAULT -> reset values of REQ-027 next edge; FAULT cleared.
REQ-034 Bench SHALL cover: lock_s rising on the same edge the timer hits 20 -> SETTLE entered, RETRY_CNT unchanged.
